// File: rtl/multi_cycle_fsm_pkg.sv
// Shared state encodings, opcode values and opcode classification for the core sequencer.
package multi_cycle_fsm_pkg;

  localparam int STATE_LEN = 3;
  localparam int OPCODE_W  = 6;

  typedef enum logic [STATE_LEN-1:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_R_TYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J      = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ    = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI   = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_ORI    = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LW     = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW     = 6'h2B;

  // Opcodes the core can execute; anything else retires as a no-op.
  function automatic logic is_known_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R_TYPE, OP_J, OP_BEQ, OP_ADDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  // ALU-result instructions that write back straight after EX.
  function automatic logic is_alu_wb_op(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_R_TYPE, OP_ADDI, OP_ORI: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_fsm_wait_timer.sv
// Counts consecutive stalled memory cycles; shared by the IF and MEM states.
module multi_cycle_fsm_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TMR_W = $clog2(WAIT_MAX + 1);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  assign expired_o = (cnt_q >= TMR_W'(WAIT_MAX));

  // Next count: clear wins, then saturating increment while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_cycle_fsm.sv
// Multi-cycle MIPS sequencer: IF/ID/EX/MEM/WB stepping, datapath enables,
// halt handling, memory-timeout bus error and cycle/retire counters.
module multi_cycle_fsm
  import multi_cycle_fsm_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 halt_req,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic [STATE_LEN-1:0] state,
  output logic                 imem_req,
  output logic                 dmem_req,
  output logic                 ir_write_en,
  output logic                 pc_inc_en,
  output logic                 pc_branch_en,
  output logic                 pc_jump_en,
  output logic                 rf_write_gate,
  output logic                 retire,
  output logic                 illegal_instr,
  output logic                 bus_error,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     retire_cnt
);

  state_e           state_q, state_d;
  logic             bus_error_q, bus_error_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  logic imem_req_c, dmem_req_c, ir_write_en_c, pc_inc_en_c;
  logic pc_branch_en_c, pc_jump_en_c, rf_write_gate_c, retire_c, illegal_c;
  logic to_if_c;   // instruction boundary: next state would be IF
  logic err_set_c; // memory wait expired with ready still low
  logic tmr_en, tmr_expired;

  // A memory state stalls while its ready is low; any other cycle restarts the timer.
  assign tmr_en = ((state_q == ST_IF)  && !imem_ready) ||
                  ((state_q == ST_MEM) && !dmem_ready);

  multi_cycle_fsm_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!tmr_en),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // Next-state and per-state enable decode; halt_req only acts at IF boundaries.
  always_comb begin
    state_d         = ST_IF;
    imem_req_c      = 1'b0;
    dmem_req_c      = 1'b0;
    ir_write_en_c   = 1'b0;
    pc_inc_en_c     = 1'b0;
    pc_branch_en_c  = 1'b0;
    pc_jump_en_c    = 1'b0;
    rf_write_gate_c = 1'b0;
    retire_c        = 1'b0;
    illegal_c       = 1'b0;
    to_if_c         = 1'b0;
    err_set_c       = 1'b0;
    case (state_q)
      ST_IF: begin
        imem_req_c = 1'b1;
        if (imem_ready) begin
          ir_write_en_c = 1'b1;
          pc_inc_en_c   = 1'b1;
          state_d       = ST_ID;
        end else if (tmr_expired) begin
          err_set_c = 1'b1;
          state_d   = ST_HALT;
        end else begin
          to_if_c = 1'b1;
        end
      end
      ST_ID: begin
        if (opcode == OP_J) begin
          pc_jump_en_c = 1'b1;
          retire_c     = 1'b1;
          to_if_c      = 1'b1;
        end else if (!is_known_op(opcode)) begin
          illegal_c = 1'b1;
          retire_c  = 1'b1;
          to_if_c   = 1'b1;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        if (opcode == OP_BEQ) begin
          pc_branch_en_c = 1'b1;
          retire_c       = 1'b1;
          to_if_c        = 1'b1;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = ST_MEM;
        end else if (is_alu_wb_op(opcode)) begin
          state_d = ST_WB;
        end else begin
          to_if_c = 1'b1;
        end
      end
      ST_MEM: begin
        dmem_req_c = 1'b1;
        if (dmem_ready) begin
          if (opcode == OP_LW) begin
            state_d = ST_WB;
          end else begin
            retire_c = (opcode == OP_SW);
            to_if_c  = 1'b1;
          end
        end else if (tmr_expired) begin
          err_set_c = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        rf_write_gate_c = 1'b1;
        retire_c        = 1'b1;
        to_if_c         = 1'b1;
      end
      ST_HALT: begin
        state_d = (halt_req || bus_error_q) ? ST_HALT : ST_IF;
      end
      default: begin
        to_if_c = 1'b1;
      end
    endcase
    if (to_if_c) begin
      state_d = halt_req ? ST_HALT : ST_IF;
    end
  end

  // Sticky error and free-running counters (HALT cycles are not counted).
  always_comb begin
    bus_error_d  = bus_error_q | err_set_c;
    cycle_cnt_d  = (state_q != ST_HALT) ? cycle_cnt_q + CNT_W'(1) : cycle_cnt_q;
    retire_cnt_d = retire_c ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
  end

  // State, error flag and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IF;
      bus_error_q  <= 1'b0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      bus_error_q  <= bus_error_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // Enables and pulses are held low for the whole reset assertion, not just after the edge.
  assign state         = state_q;
  assign imem_req      = imem_req_c      & ~rst;
  assign dmem_req      = dmem_req_c      & ~rst;
  assign ir_write_en   = ir_write_en_c   & ~rst;
  assign pc_inc_en     = pc_inc_en_c     & ~rst;
  assign pc_branch_en  = pc_branch_en_c  & ~rst;
  assign pc_jump_en    = pc_jump_en_c    & ~rst;
  assign rf_write_gate = rf_write_gate_c & ~rst;
  assign retire        = retire_c        & ~rst;
  assign illegal_instr = illegal_c       & ~rst;
  assign bus_error     = bus_error_q;
  assign cycle_cnt     = cycle_cnt_q;
  assign retire_cnt    = retire_cnt_q;

endmodule

// File: tb/tb_multi_cycle_fsm.sv
// Self-checking bench for multi_cycle_fsm: directed scenarios plus randomized
// instruction streams compared against an instruction-route reference model.
module tb_multi_cycle_fsm;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 15;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08,
                         OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode;
  logic             halt_req, imem_ready, dmem_ready;
  logic [2:0]       state;
  logic             imem_req, dmem_req, ir_write_en, pc_inc_en, pc_branch_en, pc_jump_en;
  logic             rf_write_gate, retire, illegal_instr, bus_error;
  logic [CNT_W-1:0] cycle_cnt, retire_cnt;
  logic [12:0]      outs;

  multi_cycle_fsm #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .state(state),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write_en(ir_write_en),
    .pc_inc_en(pc_inc_en), .pc_branch_en(pc_branch_en), .pc_jump_en(pc_jump_en),
    .rf_write_gate(rf_write_gate), .retire(retire), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {state, imem_req, dmem_req, ir_write_en, pc_inc_en, pc_branch_en,
                 pc_jump_en, rf_write_gate, retire, illegal_instr, bus_error};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position along the current instruction's route.
  int          m_pos, m_wait;
  bit          m_halt, m_berr, m_loaded, rnd_mode;
  logic [31:0] m_cyc, m_ret;
  logic [5:0]  op_q[$];

  // Last sampled DUT values and observation counters.
  logic [2:0] s_state;
  logic       s_ret, s_ill, s_rf, s_ir, s_berr;
  int         n_dmem, n_mem, n_ret_obs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int route_len(input logic [5:0] op);
    case (op)
      OP_J:                         return 2;
      OP_BEQ:                       return 3;
      OP_R, OP_ADDI, OP_ORI, OP_SW: return 4;
      OP_LW:                        return 5;
      default:                      return 2;
    endcase
  endfunction

  function automatic logic [2:0] route_step(input logic [5:0] op, input int pos);
    logic [2:0] r [0:4];
    r = '{S_IF, S_ID, S_EX, S_MEM, S_WB};
    if (op == OP_R || op == OP_ADDI || op == OP_ORI) r[3] = S_WB;
    if (pos < 0 || pos > 4) return S_IF;
    return r[pos];
  endfunction

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 8))
      0: return OP_R;
      1: return OP_J;
      2: return OP_BEQ;
      3: return OP_ADDI;
      4: return OP_ORI;
      5: return OP_LW;
      6: return OP_SW;
      7: return 6'h3F;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_wait = 0; m_halt = 0; m_berr = 0; m_loaded = 0;
    m_cyc = '0; m_ret = '0;
    op_q.delete();
  endtask

  // One clock: called at posedge+1, drives inputs, checks at posedge+4, returns at next posedge+1.
  task automatic tick();
    logic [2:0]  st, es;
    int          len;
    bit          stall, done;
    logic        e_imem, e_dmem, e_ir, e_inc, e_br, e_j, e_rf, e_ret, e_ill;
    if (rnd_mode) begin
      imem_ready = ($urandom_range(0, 3) != 0);
      dmem_ready = ($urandom_range(0, 3) != 0);
      halt_req   = ($urandom_range(0, 15) == 0);
    end
    if (!m_halt && m_pos == 0 && !m_loaded) begin
      if (rnd_mode && op_q.size() == 0) op_q.push_back(rand_op());
      if (op_q.size() > 0) begin
        opcode   = op_q.pop_front();
        m_loaded = 1;
      end
    end
    #3;
    {e_imem, e_dmem, e_ir, e_inc, e_br, e_j, e_rf, e_ret, e_ill} = '0;
    stall = 0; done = 0; st = S_HALT;
    if (m_halt) begin
      es = S_HALT;
    end else begin
      st  = route_step(opcode, m_pos);
      len = route_len(opcode);
      es  = st;
      if (st == S_IF) begin
        e_imem = 1;
        if (imem_ready) begin e_ir = 1; e_inc = 1; end
        else stall = 1;
      end
      if (st == S_MEM) begin
        e_dmem = 1;
        if (!dmem_ready) stall = 1;
      end
      done = !stall && (m_pos == len - 1);
      if (done) begin
        e_ret = 1;
        case (st)
          S_ID:    if (opcode == OP_J) e_j = 1; else e_ill = 1;
          S_EX:    e_br = 1;
          S_WB:    e_rf = 1;
          default: ;
        endcase
      end
    end
    check("outs", outs, {es, e_imem, e_dmem, e_ir, e_inc, e_br, e_j, e_rf, e_ret, e_ill, m_berr});
    check("cycle_cnt", cycle_cnt, m_cyc);
    check("retire_cnt", retire_cnt, m_ret);
    s_state = state; s_ret = retire; s_ill = illegal_instr; s_rf = rf_write_gate;
    s_ir = ir_write_en; s_berr = bus_error;
    n_dmem += int'(dmem_req);
    n_mem  += int'(state == S_MEM);
    n_ret_obs += int'(retire);
    if (m_halt) begin
      if (!m_berr && !halt_req) m_halt = 0;
    end else begin
      m_cyc++;
      if (stall) begin
        if (m_wait >= WAIT_MAX) begin
          m_berr = 1; m_halt = 1; m_wait = 0;
        end else begin
          m_wait++;
          if (st == S_IF && halt_req) begin m_halt = 1; m_wait = 0; end
        end
      end else begin
        m_wait = 0;
        if (done) begin
          m_ret++; m_pos = 0; m_loaded = 0;
          if (halt_req) m_halt = 1;
        end else begin
          m_pos++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, r0;
    rnd_mode = 0; n_dmem = 0; n_mem = 0; n_ret_obs = 0;
    rst = 1'b1; opcode = OP_R; halt_req = 0; imem_ready = 1; dmem_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1; #3;
    check("rst_outs", outs, 13'd0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_retire_cnt", retire_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // R-type with ready tied high: IF, ID, EX, WB.
    op_q.push_back(OP_R);
    tick(); check("t1_s0", s_state, S_IF);
    tick(); check("t1_s1", s_state, S_ID);
    tick(); check("t1_s2", s_state, S_EX);
    tick(); check("t1_s3", s_state, S_WB); check("t1_retire", s_ret, 1);
    check("t1_back_if", state, S_IF);
    check("t1_cycle_cnt", cycle_cnt, 4);
    check("t1_retire_cnt", retire_cnt, 1);

    // LW, SW, BEQ, J back to back.
    op_q.push_back(OP_LW); op_q.push_back(OP_SW); op_q.push_back(OP_BEQ); op_q.push_back(OP_J);
    n_dmem = 0; k = 0; r0 = n_ret_obs;
    while (n_ret_obs < r0 + 4 && k < 40) begin tick(); k++; end
    check("t2_cycles", k, 14);
    check("t2_dmem_cycles", n_dmem, 2);

    // LW with data memory slow for 3 cycles.
    op_q.push_back(OP_LW);
    dmem_ready = 0; n_mem = 0;
    repeat (6) tick();
    dmem_ready = 1;
    tick();
    tick();
    check("t3a_mem_cycles", n_mem, 4);
    check("t3a_wb", s_state, S_WB);
    check("t3a_berr", s_berr, 0);

    // Fetch ready on exactly the last allowed wait cycle completes normally.
    op_q.push_back(OP_R);
    imem_ready = 0;
    repeat (15) tick();
    imem_ready = 1;
    tick();
    check("t3c_ir_write", s_ir, 1);
    check("t3c_no_berr", s_berr, 0);
    repeat (3) tick();
    check("t3c_retire", s_ret, 1);

    // Unknown opcode retires as a no-op.
    op_q.push_back(6'h3F);
    tick(); tick();
    check("t5_illegal", s_ill, 1);
    check("t5_retire", s_ret, 1);
    check("t5_no_rf", s_rf, 0);
    check("t5_back_if", state, S_IF);

    // Halt raised in EX of ADDI takes effect after WB.
    op_q.push_back(OP_ADDI);
    tick(); tick();
    halt_req = 1;
    tick(); tick();
    check("t4_wb_retire", s_ret, 1);
    check("t4_halted", state, S_HALT);
    repeat (3) tick();
    halt_req = 0;
    tick();
    check("t4_resume", state, S_IF);

    // Randomized instruction stream.
    rnd_mode = 1;
    repeat (500) tick();
    rnd_mode = 0;
    halt_req = 0; imem_ready = 1; dmem_ready = 1;
    k = 0;
    while (!(m_pos == 0 && !m_halt && !m_loaded) && k < 20) begin tick(); k++; end
    check("drain_bound", k < 20, 1);

    // Asynchronous reset in the middle of a SW memory stall.
    op_q.push_back(OP_SW);
    dmem_ready = 0;
    repeat (4) tick();
    check("t6_in_mem", s_state, S_MEM);
    #2 rst = 1'b1;
    #1;
    check("t6_outs", outs, 13'd0);
    check("t6_cycle_cnt", cycle_cnt, 0);
    check("t6_retire_cnt", retire_cnt, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; dmem_ready = 1;

    // Fetch never ready: bus error after 16 stalled cycles, sticky HALT.
    op_q.push_back(OP_R);
    imem_ready = 0;
    repeat (16) tick();
    check("t3b_halt", state, S_HALT);
    check("t3b_berr", bus_error, 1);
    imem_ready = 1;
    repeat (4) tick();
    check("t3b_still_halt", state, S_HALT);
    check("t3b_still_berr", bus_error, 1);

    rst = 1'b1;
    #3;
    check("rst2_outs", outs, 13'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;

    rnd_mode = 1;
    repeat (200) tick();
    rnd_mode = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
